// File: rtl/board_pkg.sv
// Shared board-level types and constants for the button, clock-divider and
// display blocks.
package board_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // Also the clock divider's terminal count, so both blocks agree on timing.
    localparam int DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/btn_step_pulse_if.sv
// Button-in / debounced-events-out bundle for btn_step_pulse.
interface btn_step_pulse_if #(
    parameter int COUNT_W = 8
);
    logic               btn_in;
    logic               btn_level;
    logic               step_pulse;
    logic               release_pulse;
    logic [COUNT_W-1:0] press_count;

    // Source side: drives the raw button and consumes the clean events.
    modport master (
        output btn_in,
        input  btn_level, step_pulse, release_pulse, press_count
    );

    // Debouncer side.
    modport slave (
        input  btn_in,
        output btn_level, step_pulse, release_pulse, press_count
    );
endinterface

// File: rtl/sync2.sv
// 1-bit two-flop synchronizer with synchronous active-high reset; output lags
// the input by two clock edges.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/btn_step_pulse.sv
// Debounces a raw push-button into a clean level plus one-cycle press/release
// pulses and a wrapping press counter, all in the CLK_in domain.
module btn_step_pulse
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 21,
    parameter int COUNT_W         = 8
) (
    input  logic             CLK_in,
    input  logic             Reset,
    btn_step_pulse_if.slave  bus
);
    localparam logic [1:0]       ST_IDLE         = IDLE;
    localparam logic [1:0]       ST_PRESS_WAIT   = PRESS_WAIT;
    localparam logic [1:0]       ST_HELD         = HELD;
    localparam logic [1:0]       ST_RELEASE_WAIT = RELEASE_WAIT;
    localparam logic [CNT_W-1:0] CNT_LAST        = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               s;
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               step_q, step_d;
    logic               rel_q, rel_d;
    logic [COUNT_W-1:0] count_q, count_d;

    sync2 u_sync (
        .clk_i (CLK_in),
        .rst_i (Reset),
        .d_i   (bus.btn_in),
        .q_o   (s)
    );

    // cnt never wraps: both wait states exit at CNT_LAST before incrementing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        step_d  = 1'b0;
        rel_d   = 1'b0;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    level_d = 1'b1;
                    step_d  = 1'b1;
                    count_d = count_q + COUNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                // Bouncing back high returns to HELD without a new press event.
                if (s) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_in) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            step_q  <= 1'b0;
            rel_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            step_q  <= step_d;
            rel_q   <= rel_d;
            count_q <= count_d;
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.step_pulse    = step_q;
    assign bus.release_pulse = rel_q;
    assign bus.press_count   = count_q;
endmodule

// File: doc/btn_step_pulse.md
Name: btn_step_pulse

Overview:
- Converts a bouncing, asynchronous push-button input into a clean debounced level and a single-cycle step pulse in the fast board-clock domain.
- This is the opposite path to the board clock divider: slow external event in, fast-domain pulse out.
- Drives the single-cycle CPU's manual single-step enable and the display's press counter.
- One clock domain; no derived clocks are generated.

Parameters:
- DEBOUNCE_CYCLES, 50000: number of consecutive stable synchronized samples required to accept a level change.
- CNT_W, 21: stability counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- COUNT_W, 8: width of the press counter.

Ports:
- CLK_in  input  1  fast board clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset, sampled on rising edge of CLK_in.
- btn_in  input  1  raw push-button, asynchronous, bouncing, active-high.
- btn_level  output  1  debounced button level (registered).
- step_pulse  output  1  high for exactly one CLK_in cycle per accepted press.
- release_pulse  output  1  high for exactly one CLK_in cycle per accepted release.
- press_count  output  COUNT_W  number of accepted presses, wraps modulo 2^COUNT_W.

Behaviour:
- Synchronizer:
  - 2-flop chain on btn_in; sync output s is 2 cycles behind btn_in.
  - Only s feeds the FSM.
  - The flops reset to 0.
- FSM states:
  - IDLE: s==1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT:
    - s==0 -> IDLE (bounce rejected).
    - Else cnt increments.
    - When cnt==DEBOUNCE_CYCLES-1 with s==1 -> HELD, btn_level<=1, step_pulse<=1, press_count<=press_count+1.
  - HELD: s==0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT:
    - s==1 -> HELD (bounce rejected; no new step_pulse).
    - Else cnt increments.
    - When cnt==DEBOUNCE_CYCLES-1 with s==0 -> IDLE, btn_level<=0, release_pulse<=1.
- Latency: step_pulse asserts exactly 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after btn_in first rises and stays high. release_pulse uses the same timing after release.
- Outputs are registered.
  - step_pulse and release_pulse default to 0 every cycle.
  - They are never high simultaneously and never high two consecutive cycles.
- press_count wraps from 2^COUNT_W-1 to 0 with no flag.
- cnt saturates logic-free: the FSM leaves the wait state at the terminal value, so cnt never wraps.
- Reset:
  - Values: state=IDLE, cnt=0, sync flops=0, btn_level=0, step_pulse=0, release_pulse=0, press_count=0.
  - Reset wins over all other events in the same cycle.
  - Reset while HELD with btn_in still high: the FSM re-debounces from IDLE, so a fresh step_pulse follows after full latency. This re-arm behaviour is required.
- Glitch shorter than DEBOUNCE_CYCLES: no output change.
- The same rule applies to a release glitch while HELD.

Decomposition:
- Shared package board_pkg:
  - State enum: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT (2-bit).
  - Default constant DEBOUNCE_CYCLES_DEF=50000, shared with the clock divider's terminal count.
- Sub-module sync2 (1-bit two-flop synchronizer with synchronous reset). Instantiated once here and reusable for other board inputs.

Test Plan:
- Use DEBOUNCE_CYCLES=4 for all scenarios.
- Clean press: Reset 2 cycles, then btn_in=1 held 20 cycles -> step_pulse high exactly one cycle, 7 cycles after rise; btn_level=1 from that cycle; press_count=1.
- Bounce rejection: btn_in toggles 1,0,1,0 at 2-cycle spacing, then stays 0 -> no step_pulse, btn_level stays 0, press_count=0.
- Bouncy press then release:
  - btn_in 1,0,1 (1-cycle spacing), then high 10 cycles -> exactly one step_pulse.
  - Then btn_in=0 held 10 cycles -> one release_pulse 7 cycles after the fall; btn_level=0.
- Release glitch: while HELD, btn_in=0 for 2 cycles then 1 -> no release_pulse, btn_level stays 1, no additional step_pulse.
- Wrap: 256 clean press/release pairs with COUNT_W=8 -> press_count returns to 0; 256 step_pulses counted.
- Reset mid-operation:
  - Assert Reset while HELD with btn_in=1 -> next cycle all outputs 0, press_count=0.
  - After Reset deasserts -> step_pulse reasserts 7 cycles later; press_count=1.
